pipe_shiftadd_mpy: RTL and testbench

//  Parametrised pipelined shift-and-add multiplier, successor to the fixed 2-bit/stage

---
 rtl/fft_pkg.sv | 23 ++
 rtl/shiftadd_stage.sv | 64 ++++++
 rtl/pipe_shiftadd_mpy.sv | 153 +++++++++++++++
 tb/tb_pipe_shiftadd_mpy.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and sizing helpers for the FFT datapath blocks.
package fft_pkg;

    localparam int ROUND_TRUNC = 0;
    localparam int ROUND_CONV  = 1;

    // Number of LUTB-bit digits needed to cover an aw-bit operand.
    function automatic int tlen(input int aw, input int lutb);
        return (aw + lutb - 1) / lutb;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shiftadd_stage.sv
// One accumulate step: adds (digit * b) << SHIFT into the running sum and
// forwards the remaining multiplier digits plus sample sideband.
module shiftadd_stage #(
    parameter int LUTB  = 2,
    parameter int PAW   = 8,
    parameter int BW    = 12,
    parameter int ACCW  = 21,
    parameter int TW    = 4,
    parameter int SHIFT = 0
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            ce,
    input  logic            valid,
    input  logic            sgn,
    input  logic            mode,
    input  logic [TW-1:0]   tag,
    input  logic [PAW-1:0]  a_rem,
    input  logic [BW-1:0]   b,
    input  logic [ACCW-1:0] acc,
    output logic            valid_reg,
    output logic            sgn_reg,
    output logic            mode_reg,
    output logic [TW-1:0]   tag_reg,
    output logic [PAW-1:0]  a_rem_reg,
    output logic [BW-1:0]   b_reg,
    output logic [ACCW-1:0] acc_reg
);

    logic [LUTB-1:0]    digit;
    logic [LUTB+BW-1:0] pp_next;
    logic [ACCW-1:0]    acc_next;

    assign digit = a_rem[LUTB-1:0];

    // Digit-selected multiple of b built from shifted copies; no multiplier.
    always_comb begin
        pp_next = '0;
        for (int j = 0; j < LUTB; j++) begin
            if (digit[j]) begin
                pp_next = pp_next + ((LUTB+BW)'(b) << j);
            end
        end
    end

    assign acc_next = acc + (ACCW'(pp_next) << SHIFT);

    always_ff @(posedge clk) begin
        if (ce) begin
            sgn_reg   <= sgn;
            mode_reg  <= mode;
            tag_reg   <= tag;
            a_rem_reg <= a_rem >> LUTB;
            b_reg     <= b;
            acc_reg   <= acc_next;
        end
        if (srst) begin
            valid_reg <= 1'b0;
        end else if (ce) begin
            valid_reg <= valid;
        end
    end

endmodule

// File: rtl/pipe_shiftadd_mpy.sv
// Pipelined signed/unsigned shift-and-add multiplier with convergent rounding
// to OW bits and a tag sideband travelling with each sample.
module pipe_shiftadd_mpy
    import fft_pkg::*;
#(
    parameter int IAW  = 8,
    parameter int IBW  = 12,
    parameter int LUTB = 2,
    parameter int OW   = 20,
    parameter int TW   = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ce,
    input  logic            i_valid,
    input  logic            i_signed,
    input  logic [IAW-1:0]  i_a,
    input  logic [IBW-1:0]  i_b,
    input  logic [TW-1:0]   i_tag,
    output logic            o_valid,
    output logic [TW-1:0]   o_tag,
    output logic [OW-1:0]   o_r
);

    localparam int AW   = (IAW <= IBW) ? IAW : IBW;
    localparam int BW   = (IAW <= IBW) ? IBW : IAW;
    localparam int TLEN = tlen(AW, LUTB);
    localparam int PAW  = TLEN * LUTB;
    localparam int PW   = AW + BW;
    localparam int ACCW = PW + 1;
    localparam int DROP = PW - OW;

    logic [AW-1:0] a_raw;
    logic [BW-1:0] b_raw;
    logic [AW-1:0] a_mag;
    logic [BW-1:0] b_mag;

    // The narrower operand drives the digit chain so its length follows AW.
    if (IAW <= IBW) begin : g_noswap
        assign a_raw = i_a;
        assign b_raw = i_b;
    end else begin : g_swap
        assign a_raw = i_b;
        assign b_raw = i_a;
    end

    assign a_mag = (i_signed && a_raw[AW-1]) ? -a_raw : a_raw;
    assign b_mag = (i_signed && b_raw[BW-1]) ? -b_raw : b_raw;

    logic            valid0_reg, sgn0_reg, mode0_reg;
    logic [TW-1:0]   tag0_reg;
    logic [PAW-1:0]  a0_reg;
    logic [BW-1:0]   b0_reg;

    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            sgn0_reg  <= i_signed & (a_raw[AW-1] ^ b_raw[BW-1]);
            mode0_reg <= i_signed;
            tag0_reg  <= i_tag;
            a0_reg    <= PAW'(a_mag);
            b0_reg    <= b_mag;
        end
        if (i_reset) begin
            valid0_reg <= 1'b0;
        end else if (i_ce) begin
            valid0_reg <= i_valid;
        end
    end

    logic            valid_s [TLEN+1];
    logic            sgn_s   [TLEN+1];
    logic            mode_s  [TLEN+1];
    logic [TW-1:0]   tag_s   [TLEN+1];
    logic [PAW-1:0]  a_s     [TLEN+1];
    logic [BW-1:0]   b_s     [TLEN+1];
    logic [ACCW-1:0] acc_s   [TLEN+1];

    assign valid_s[0] = valid0_reg;
    assign sgn_s[0]   = sgn0_reg;
    assign mode_s[0]  = mode0_reg;
    assign tag_s[0]   = tag0_reg;
    assign a_s[0]     = a0_reg;
    assign b_s[0]     = b0_reg;
    assign acc_s[0]   = '0;

    for (genvar gi = 0; gi < TLEN; gi++) begin : g_stage
        shiftadd_stage #(
            .LUTB (LUTB),
            .PAW  (PAW),
            .BW   (BW),
            .ACCW (ACCW),
            .TW   (TW),
            .SHIFT(gi * LUTB)
        ) u_stage (
            .clk      (i_clk),
            .srst     (i_reset),
            .ce       (i_ce),
            .valid    (valid_s[gi]),
            .sgn      (sgn_s[gi]),
            .mode     (mode_s[gi]),
            .tag      (tag_s[gi]),
            .a_rem    (a_s[gi]),
            .b        (b_s[gi]),
            .acc      (acc_s[gi]),
            .valid_reg(valid_s[gi+1]),
            .sgn_reg  (sgn_s[gi+1]),
            .mode_reg (mode_s[gi+1]),
            .tag_reg  (tag_s[gi+1]),
            .a_rem_reg(a_s[gi+1]),
            .b_reg    (b_s[gi+1]),
            .acc_reg  (acc_s[gi+1])
        );
    end

    logic [ACCW-1:0] acc_f;
    logic [ACCW-1:0] acc_signed;
    logic [PW-1:0]   p;
    logic [OW-1:0]   r_next;
    logic            unused_tail;

    assign acc_f       = acc_s[TLEN];
    assign acc_signed  = sgn_s[TLEN] ? -acc_f : acc_f;
    assign p           = acc_signed[PW-1:0];
    assign unused_tail = ^{a_s[TLEN], b_s[TLEN], acc_signed[PW]};

    if (DROP == 0) begin : g_exact
        logic unused_mode;
        assign unused_mode = mode_s[TLEN];
        assign r_next      = p;
    end else begin : g_round
        logic [PW:0] rsum;
        logic        unused_low;
        // Ties go to even: bias is half-1 plus the kept LSB.
        assign rsum = {1'b0, p} + (PW+1)'((1 << (DROP-1)) - 1)
                    + {{PW{1'b0}}, p[DROP]};
        assign unused_low = ^rsum[DROP-1:0];
        // Only unsigned samples can carry past the top; signed wraps are legitimate.
        assign r_next = (!mode_s[TLEN] && rsum[PW]) ? '1 : rsum[PW-1:DROP];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_r     <= '0;
            o_tag   <= '0;
        end else if (i_ce) begin
            o_valid <= valid_s[TLEN];
            o_r     <= r_next;
            o_tag   <= tag_s[TLEN];
        end
    end

endmodule

// File: tb/tb_pipe_shiftadd_mpy.sv
// Randomized and directed bench for pipe_shiftadd_mpy across six configurations
// sharing one stimulus stream, checked against an arithmetic rounding model.
module tb_pipe_shiftadd_mpy;

    localparam int N = 6;

    logic        clk = 1'b0;
    logic        rst, ce, vin, sin;
    logic [12:0] a_in;
    logic [11:0] b_in;
    logic [3:0]  tag_in;

    logic [N-1:0]       ov;
    logic [N-1:0][3:0]  otg;
    logic [19:0]        r0, r3, r4, r5;
    logic [11:0]        r1;
    logic [3:0]         r2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_shiftadd_mpy #(.IAW(8), .IBW(12), .LUTB(2), .OW(20), .TW(4)) u_ow20 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vin), .i_signed(sin),
        .i_a(a_in[7:0]), .i_b(b_in), .i_tag(tag_in),
        .o_valid(ov[0]), .o_tag(otg[0]), .o_r(r0));
    pipe_shiftadd_mpy #(.IAW(8), .IBW(12), .LUTB(2), .OW(12), .TW(4)) u_ow12 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vin), .i_signed(sin),
        .i_a(a_in[7:0]), .i_b(b_in), .i_tag(tag_in),
        .o_valid(ov[1]), .o_tag(otg[1]), .o_r(r1));
    pipe_shiftadd_mpy #(.IAW(8), .IBW(12), .LUTB(2), .OW(4), .TW(4)) u_ow4 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vin), .i_signed(sin),
        .i_a(a_in[7:0]), .i_b(b_in), .i_tag(tag_in),
        .o_valid(ov[2]), .o_tag(otg[2]), .o_r(r2));
    pipe_shiftadd_mpy #(.IAW(8), .IBW(12), .LUTB(1), .OW(20), .TW(4)) u_l1 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vin), .i_signed(sin),
        .i_a(a_in[7:0]), .i_b(b_in), .i_tag(tag_in),
        .o_valid(ov[3]), .o_tag(otg[3]), .o_r(r3));
    pipe_shiftadd_mpy #(.IAW(8), .IBW(12), .LUTB(3), .OW(20), .TW(4)) u_l3 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vin), .i_signed(sin),
        .i_a(a_in[7:0]), .i_b(b_in), .i_tag(tag_in),
        .o_valid(ov[4]), .o_tag(otg[4]), .o_r(r4));
    pipe_shiftadd_mpy #(.IAW(13), .IBW(7), .LUTB(2), .OW(20), .TW(4)) u_swap (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vin), .i_signed(sin),
        .i_a(a_in), .i_b(b_in[6:0]), .i_tag(tag_in),
        .o_valid(ov[5]), .o_tag(otg[5]), .o_r(r5));

    function automatic int cfg_iaw(input int i); return (i == 5) ? 13 : 8; endfunction
    function automatic int cfg_ibw(input int i); return (i == 5) ? 7 : 12; endfunction
    function automatic int cfg_ow(input int i);
        return (i == 1) ? 12 : (i == 2) ? 4 : 20;
    endfunction
    function automatic int cfg_lat(input int i);
        return (i == 3) ? 10 : (i == 4) ? 5 : 6;
    endfunction

    function automatic longint get_r(input int i);
        case (i)
            0:       return longint'(r0);
            1:       return longint'(r1);
            2:       return longint'(r2);
            3:       return longint'(r3);
            4:       return longint'(r4);
            default: return longint'(r5);
        endcase
    endfunction

    // Exact product, then round-half-to-even on DROP bits, saturating unsigned overflow.
    function automatic longint model(input logic [12:0] a, input logic [11:0] b,
                                     input logic s, input int wa, input int wb, input int wo);
        longint av, bv, p, q, rem, half, lim;
        int     drop;
        av = longint'(a) & ((longint'(1) << wa) - 1);
        bv = longint'(b) & ((longint'(1) << wb) - 1);
        if (s && av[wa-1]) av = av - (longint'(1) << wa);
        if (s && bv[wb-1]) bv = bv - (longint'(1) << wb);
        p    = av * bv;
        drop = wa + wb - wo;
        lim  = longint'(1) << wo;
        q    = p;
        if (drop > 0) begin
            q    = p >>> drop;
            rem  = p - (q <<< drop);
            half = longint'(1) << (drop - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (!s && q >= lim) q = lim - 1;
        end
        return q & (lim - 1);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted sample, one read pointer per configuration.
    logic [12:0] sa [4096];
    logic [11:0] sb [4096];
    logic        ss [4096];
    logic [3:0]  st [4096];
    int          wr = 0;
    int          rd [N];
    int          ov_cnt [N];
    int          acc_cnt = 0;
    bit          adv = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            adv     = 1'b0;
            acc_cnt = 0;
            for (int i = 0; i < N; i++) begin
                rd[i]     = wr;
                ov_cnt[i] = 0;
            end
        end else begin
            adv = ce;
            if (ce && vin) begin
                sa[wr] = a_in; sb[wr] = b_in; ss[wr] = sin; st[wr] = tag_in;
                wr++;
                acc_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (adv) begin
            for (int i = 0; i < N; i++) begin
                if (ov[i]) begin
                    ov_cnt[i]++;
                    if (rd[i] >= wr) begin
                        chk($sformatf("sb%0d_unexpected_valid", i), 1, 0);
                    end else begin
                        longint e;
                        e = model(sa[rd[i]], sb[rd[i]], ss[rd[i]], cfg_iaw(i), cfg_ibw(i), cfg_ow(i));
                        if (i == 0)
                            $display("txn %0d: a=0x%0h b=0x%0h signed=%0d tag=%0h -> r=0x%0h (model 0x%0h)",
                                     rd[i], sa[rd[i]][7:0], sb[rd[i]], ss[rd[i]], otg[i], get_r(i), e);
                        chk($sformatf("sb%0d_r", i), get_r(i), e);
                        chk($sformatf("sb%0d_tag", i), longint'(otg[i]), longint'(st[rd[i]]));
                        rd[i]++;
                    end
                end
            end
        end
    end

    task automatic directed(input logic [12:0] a, input logic [11:0] b, input logic s,
                            input logic [3:0] t, input longint e20, input longint e12,
                            input longint e4);
        @(posedge clk); #2;
        ce = 1'b1; vin = 1'b1; a_in = a; b_in = b; sin = s; tag_in = t;
        @(posedge clk); #2;
        vin = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(posedge clk); #2;
            if (c < 6) chk("dir_early_valid", longint'(ov[0]), 0);
        end
        chk("dir_valid_at_6", longint'(ov[0]), 1);
        chk("dir_r_ow20", longint'(r0), e20);
        chk("dir_r_ow12", longint'(r1), e12);
        chk("dir_r_ow4", longint'(r2), e4);
        chk("dir_tag", longint'(otg[0]), longint'(t));
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; vin = 1'b0; sin = 1'b0;
        a_in = '0; b_in = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset_valid%0d", i), longint'(ov[i]), 0);
            chk($sformatf("reset_r%0d", i), get_r(i), 0);
            chk($sformatf("reset_tag%0d", i), longint'(otg[i]), 0);
        end
        rst = 1'b0; ce = 1'b1;

        directed(13'h080, 12'h800, 1'b1, 4'h1, 64'h40000, 64'h400, 64'h4);
        directed(13'h080, 12'h7FF, 1'b1, 4'h2, 64'hC0080, 64'hC00, 64'hC);
        directed(13'h000, 12'h800, 1'b1, 4'h3, 64'h0,     64'h0,   64'h0);
        directed(13'h0FF, 12'hFFF, 1'b0, 4'h4, 64'hFEF01, 64'hFEF, 64'hF);
        directed(13'h0FF, 12'hFFF, 1'b1, 4'h5, 64'h1,     64'h0,   64'h0);
        directed(13'h003, 12'h080, 1'b0, 4'h6, 64'h180,   64'h2,   64'h0);
        directed(13'h005, 12'h080, 1'b0, 4'h7, 64'h280,   64'h2,   64'h0);

        // Reset in the middle of three back-to-back samples.
        @(posedge clk); #2;
        vin = 1'b1; sin = 1'b1; a_in = 13'h1F85; b_in = 12'h123; tag_in = 4'h8;
        @(posedge clk); #2;
        a_in = 13'h0044; b_in = 12'hABC; tag_in = 4'h9;
        @(posedge clk); #2;
        a_in = 13'h0011; b_in = 12'h0FF; tag_in = 4'hB; rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0; vin = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #2;
            for (int i = 0; i < N; i++) chk($sformatf("rstmid_quiet%0d", i), longint'(ov[i]), 0);
        end
        vin = 1'b1; sin = 1'b0; a_in = 13'd7; b_in = 12'd9; tag_in = 4'hA;
        @(posedge clk); #2;
        vin = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            @(posedge clk); #2;
            for (int i = 0; i < N; i++) begin
                if (c < cfg_lat(i)) begin
                    chk($sformatf("post_rst_early%0d", i), longint'(ov[i]), 0);
                end else if (c == cfg_lat(i)) begin
                    chk($sformatf("post_rst_valid%0d", i), longint'(ov[i]), 1);
                    chk($sformatf("post_rst_r%0d", i), get_r(i), (cfg_ow(i) == 20) ? 63 : 0);
                end
            end
        end

        // Random stream with pseudo-random clock enable and extreme operands mixed in.
        for (int n = 0; n < 240; n++) begin
            int ka, kb;
            @(posedge clk); #2;
            ce     = ($urandom_range(0, 3) != 0);
            vin    = ($urandom_range(0, 9) < 7);
            sin    = 1'($urandom_range(0, 1));
            tag_in = 4'($urandom);
            ka     = $urandom_range(0, 5);
            kb     = $urandom_range(0, 5);
            a_in   = (ka == 0) ? 13'h1000 : (ka == 1) ? 13'h1FFF : (ka == 2) ? 13'h0080 : 13'($urandom);
            b_in   = (kb == 0) ? 12'h800 : (kb == 1) ? 12'hFFF : (kb == 2) ? 12'h040 : 12'($urandom);
        end
        @(posedge clk); #2;
        ce = 1'b1; vin = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("valid_count%0d", i), longint'(ov_cnt[i]), longint'(acc_cnt));
            chk($sformatf("drained%0d", i), longint'(rd[i]), longint'(wr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
